sram_boot_loader: RTL

//  Boot-time loader sitting directly upstream of the SoC SRAM instruction port.

---
 rtl/sram_boot_loader_pkg.sv | 21 ++
 rtl/sram_boot_loader_if.sv | 25 ++
 rtl/sram_boot_loader_packer.sv | 45 ++++
 rtl/sram_boot_loader.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/sram_boot_loader_pkg.sv
// Shared types and constants for the SRAM boot loader: FSM state encoding,
// length-field size and the little-endian byte shift helper.
package sram_boot_loader_pkg;

    localparam int unsigned LEN_BYTES = 4;

    typedef enum logic [2:0] {
        ST_LEN   = 3'd0,
        ST_DATA  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CSUM  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    // Shifts a new byte in from the top so the first byte ends up in bits 7:0.
    function automatic logic [31:0] le_shift(input logic [31:0] acc, input logic [7:0] b);
        return {b, acc[31:8]};
    endfunction

endpackage

// File: rtl/sram_boot_loader_if.sv
// Boot byte stream plus SRAM i-port write bus. Signal suffixes are seen from the
// loader, which uses the slave modport; the byte source / SRAM side uses master.
interface sram_boot_loader_if #(
    parameter int DATA_W      = 32,
    parameter int SRAM_ADDR_W = 15
);
    logic                     s_valid_i;
    logic [7:0]               s_data_i;
    logic                     s_ready_o;
    logic                     i_avalid_o;
    logic [SRAM_ADDR_W-3:0]   i_addr_o;
    logic [DATA_W-1:0]        i_wdata_o;
    logic [DATA_W/8-1:0]      i_wstrb_o;
    logic                     i_ready_i;

    modport slave (
        input  s_valid_i, s_data_i, i_ready_i,
        output s_ready_o, i_avalid_o, i_addr_o, i_wdata_o, i_wstrb_o
    );

    modport master (
        output s_valid_i, s_data_i, i_ready_i,
        input  s_ready_o, i_avalid_o, i_addr_o, i_wdata_o, i_wstrb_o
    );
endinterface

// File: rtl/sram_boot_loader_packer.sv
// Byte-lane accumulator: places successive bytes into lanes 0..3 of a word,
// tracks the strobe per filled lane and clears once the word has been written.
module sram_boot_packer #(
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                rst_i,
    input  logic                push_i,
    input  logic [7:0]          data_i,
    input  logic                clear_i,
    output logic [DATA_W-1:0]   word_o,
    output logic [DATA_W/8-1:0] strb_o,
    output logic [2:0]          lane_cnt_o,
    output logic                full_o
);
    logic [DATA_W-1:0]   word_q;
    logic [DATA_W/8-1:0] strb_q;
    logic [2:0]          lane_q;

    assign full_o = (lane_q == 3'd4);

    // Lane fill / clear; pushes into a full word are ignored.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q <= '0;
            strb_q <= '0;
            lane_q <= 3'd0;
        end else if (cke_i) begin
            if (clear_i) begin
                word_q <= '0;
                strb_q <= '0;
                lane_q <= 3'd0;
            end else if (push_i && !full_o) begin
                word_q[{lane_q[1:0], 3'b000} +: 8] <= data_i;
                strb_q[lane_q[1:0]]                <= 1'b1;
                lane_q                             <= lane_q + 3'd1;
            end
        end
    end

    assign word_o     = word_q;
    assign strb_o     = strb_q;
    assign lane_cnt_o = lane_q;
endmodule

// File: rtl/sram_boot_loader.sv
// Boot loader: length-prefixed byte stream -> little-endian SRAM word writes,
// CPU held in reset until the image is in. Optional checksum: SRAM_BOOT_LOADER_CHECKSUM_EN.
module sram_boot_loader
    import sram_boot_loader_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SRAM_ADDR_W = 15
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                arst_i,
    sram_boot_loader_if.slave   bus,
    output logic                boot_done_o,
    output logic                boot_err_o,
    output logic                cpu_rst_o
);
    localparam int unsigned AW = SRAM_ADDR_W - 2;
    localparam int unsigned RW = SRAM_ADDR_W + 1;
    localparam logic [31:0] LEN_MAX = 32'd1 << SRAM_ADDR_W;

    state_e          state_q;
    logic [31:0]     len_q;
    logic [1:0]      byte_cnt_q;
    logic [RW-1:0]   rem_q;
    logic [AW-1:0]   addr_q;
    logic            s_ready_q;
    logic            avalid_q;
    logic            done_q;
    logic            err_q;
    logic            cpu_rst_q;
`ifdef SRAM_BOOT_LOADER_CHECKSUM_EN
    logic [31:0]     sum_q;
`endif

    logic            xfer_s;
    logic [31:0]     len_shift_s;
    logic [DATA_W-1:0]   word_s;
    logic [DATA_W/8-1:0] strb_s;
    logic [2:0]      lane_cnt_s;
    logic            full_s;
    logic            accept_s;

    assign xfer_s      = bus.s_valid_i & s_ready_q & cke_i;
    assign len_shift_s = le_shift(len_q, bus.s_data_i);
    assign accept_s    = (state_q == ST_WRITE) & bus.i_ready_i & cke_i;

    sram_boot_packer #(.DATA_W(DATA_W)) u_packer (
        .clk_i      (clk_i),
        .cke_i      (cke_i),
        .rst_i      (arst_i),
        .push_i     (xfer_s && (state_q == ST_DATA) && !full_s),
        .data_i     (bus.s_data_i),
        .clear_i    (accept_s),
        .word_o     (word_s),
        .strb_o     (strb_s),
        .lane_cnt_o (lane_cnt_s),
        .full_o     (full_s)
    );

    // Loader FSM with registered handshake and status outputs.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state_q    <= ST_LEN;
            len_q      <= 32'd0;
            byte_cnt_q <= 2'd0;
            rem_q      <= '0;
            addr_q     <= '0;
            s_ready_q  <= 1'b0;
            avalid_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_rst_q  <= 1'b1;
`ifdef SRAM_BOOT_LOADER_CHECKSUM_EN
            sum_q      <= 32'd0;
`endif
        end else if (cke_i) begin
            case (state_q)
                ST_LEN: begin
                    s_ready_q <= 1'b1;
                    if (xfer_s) begin
                        len_q      <= len_shift_s;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'(LEN_BYTES - 1)) begin
                            if (len_shift_s > LEN_MAX) begin
                                state_q   <= ST_ERR;
                                s_ready_q <= 1'b0;
                                err_q     <= 1'b1;
                            end else if (len_shift_s == 32'd0) begin
`ifdef SRAM_BOOT_LOADER_CHECKSUM_EN
                                state_q   <= ST_CSUM;
`else
                                state_q   <= ST_DONE;
                                s_ready_q <= 1'b0;
                                done_q    <= 1'b1;
                                cpu_rst_q <= 1'b0;
`endif
                            end else begin
                                state_q <= ST_DATA;
                                rem_q   <= len_shift_s[RW-1:0];
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer_s) begin
                        rem_q <= rem_q - RW'(1);
                        if (lane_cnt_s == 3'd3 || rem_q == RW'(1)) begin
                            state_q   <= ST_WRITE;
                            s_ready_q <= 1'b0;
                            avalid_q  <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (bus.i_ready_i) begin
                        avalid_q <= 1'b0;
                        addr_q   <= addr_q + AW'(1);
`ifdef SRAM_BOOT_LOADER_CHECKSUM_EN
                        sum_q    <= sum_q + word_s;
`endif
                        if (rem_q != '0) begin
                            state_q   <= ST_DATA;
                            s_ready_q <= 1'b1;
`ifdef SRAM_BOOT_LOADER_CHECKSUM_EN
                        end else begin
                            state_q   <= ST_CSUM;
                            s_ready_q <= 1'b1;
                        end
`else
                        end else begin
                            state_q   <= ST_DONE;
                            done_q    <= 1'b1;
                            cpu_rst_q <= 1'b0;
                        end
`endif
                    end
                end
`ifdef SRAM_BOOT_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (xfer_s) begin
                        len_q      <= len_shift_s;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'(LEN_BYTES - 1)) begin
                            s_ready_q <= 1'b0;
                            if (len_shift_s == sum_q) begin
                                state_q   <= ST_DONE;
                                done_q    <= 1'b1;
                                cpu_rst_q <= 1'b0;
                            end else begin
                                state_q <= ST_ERR;
                                err_q   <= 1'b1;
                            end
                        end
                    end
                end
`endif
                ST_DONE, ST_ERR: begin
                    s_ready_q <= 1'b0;
                    avalid_q  <= 1'b0;
                end
                default: begin
                    state_q   <= ST_ERR;
                    s_ready_q <= 1'b0;
                    avalid_q  <= 1'b0;
                    err_q     <= 1'b1;
                end
            endcase
        end
    end

    assign bus.s_ready_o  = s_ready_q;
    assign bus.i_avalid_o = avalid_q;
    assign bus.i_addr_o   = addr_q;
    assign bus.i_wdata_o  = word_s;
    assign bus.i_wstrb_o  = strb_s;
    assign boot_done_o    = done_q;
    assign boot_err_o     = err_q;
    assign cpu_rst_o      = cpu_rst_q;
endmodule
